// File: rtl/logs_iter_sched_pkg.sv
// Shared types and constants for the logistic-map iteration scheduler.
// Holds the FSM encoding and sizing helpers used by the interface and top.
package logs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL1,
    MUL2,
    DONE
  } state_t;

  localparam int FRAC_DEF  = 8;
  localparam int N_OSC_DEF = 4;
  localparam int INITIAL_X = 1 << (FRAC_DEF - 4);
  localparam int CNT_W     = $clog2(FRAC_DEF + 1);

  function automatic int init_x(input int frac);
    return 1 << (frac - 4);
  endfunction

  function automatic int cnt_w(input int frac);
    return $clog2(frac + 1);
  endfunction

  function automatic int slot_w(input int n_osc);
    return (n_osc > 1) ? $clog2(n_osc) : 1;
  endfunction

endpackage

// File: rtl/logs_iter_sched_if.sv
// Control/result bundle between the oscillator owner and the iterator.
// The owner drives the master side; the scheduler is the slave.
interface logs_iter_sched_if
  import logs_pkg::*;
#(
  parameter int FRAC  = 8,
  parameter int N_OSC = 4
);

  localparam int SW = slot_w(N_OSC);

  logic            enable;
  logic            start;
  logic [FRAC+1:0] r_in;
  logic            seed_load;
  logic [FRAC-1:0] seed_x;
  logic [FRAC-1:0] x_out;
  logic            x_valid;
  logic [SW-1:0]   slot;
  logic            busy;

  modport master (
    output enable, start, r_in, seed_load, seed_x,
    input  x_out, x_valid, slot, busy
  );

  modport slave (
    input  enable, start, r_in, seed_load, seed_x,
    output x_out, x_valid, slot, busy
  );

endinterface

// File: rtl/logs_iter_sched_mul.sv
// LSB-first serial shift-add multiplier, one bit of b per step.
// product is the accumulator value after the current cycle's step.
module logs_serial_mul #(
  parameter int AW = 10,
  parameter int BW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic [AW-1:0]   a,
  input  logic [BW-1:0]   b,
  output logic [AW+BW-1:0] product
);

  logic [AW+BW-1:0] acc;
  logic [AW+BW-1:0] a_sh;
  logic [BW-1:0]    b_sh;

  assign product = acc + (b_sh[0] ? a_sh : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      a_sh <= '0;
      b_sh <= '0;
    end else if (load) begin
      acc  <= '0;
      a_sh <= {{BW{1'b0}}, a};
      b_sh <= b;
    end else if (step) begin
      acc  <= product;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
    end
  end

endmodule

// File: rtl/logs_iter_sched.sv
// Logistic-map iterator x' = r*x*(1-x) on one shared serial multiplier.
// Results are tagged with a round-robin oscillator slot.
module logs_iter_sched
  import logs_pkg::*;
#(
  parameter int FRAC  = 8,
  parameter int N_OSC = 4
) (
  input logic              clk,
  input logic              reset,
  logs_iter_sched_if.slave bus
);

  localparam int CW = cnt_w(FRAC);
  localparam int SW = slot_w(N_OSC);
  localparam int PW = 2 * FRAC + 2;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [FRAC+1:0] r_q;
  logic [FRAC-1:0] x_q;
  logic [SW-1:0]   slot_q;
  logic            valid_q;
  logic            busy_q;

  logic            mul_load;
  logic            mul_step;
  logic [FRAC+1:0] mul_a;
  logic [FRAC-1:0] mul_b;
  logic [PW-1:0]   prod;
  logic [FRAC-1:0] p1;
  logic [FRAC-1:0] res;
  logic            last;
  logic            accept;
  logic            unused_lo;

  assign last      = (cnt == CW'(FRAC - 1));
  assign p1        = prod[2*FRAC-1:FRAC];
  assign unused_lo = ^prod[FRAC-1:0];
  assign accept    = !bus.seed_load && bus.start && bus.enable;

  // Saturate on overflow; never land on the 0 fixed point.
  always_comb begin
    res = prod[2*FRAC-1:FRAC];
    if (|prod[PW-1:2*FRAC])
      res = '1;
    else if (res == '0)
      res = FRAC'(1);
  end

  always_comb begin
    mul_load = 1'b0;
    mul_step = 1'b0;
    mul_a    = {2'b00, x_q};
    mul_b    = ~x_q;
    unique case (state)
      IDLE: mul_load = accept;
      MUL1: begin
        mul_step = 1'b1;
        mul_load = last;
        mul_a    = r_q;
        mul_b    = p1;
      end
      MUL2: mul_step = 1'b1;
      default: ;
    endcase
  end

  logs_serial_mul #(
    .AW(FRAC + 2),
    .BW(FRAC)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .load   (mul_load),
    .step   (mul_step),
    .a      (mul_a),
    .b      (mul_b),
    .product(prod)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      r_q     <= '0;
      x_q     <= FRAC'(init_x(FRAC));
      slot_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          valid_q <= 1'b0;
          if (bus.seed_load) begin
            x_q <= bus.seed_x;
          end else if (accept) begin
            r_q    <= bus.r_in;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= MUL1;
          end
        end
        MUL1: begin
          if (last) begin
            cnt   <= '0;
            state <= MUL2;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MUL2: begin
          if (last) begin
            x_q     <= res;
            valid_q <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          slot_q  <= (slot_q == SW'(N_OSC - 1)) ? '0 : slot_q + 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.x_out   = x_q;
  assign bus.x_valid = valid_q;
  assign bus.slot    = slot_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_logs_iter_sched.sv
// Directed bench for logs_iter_sched: vector table plus multi-cycle sequences.
// FRAC=8, N_OSC=4; expected values are hand-derived or from a small model.
module tb_logs_iter_sched;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  logs_iter_sched_if #(.FRAC(8), .N_OSC(4)) bus ();

  logs_iter_sched #(.FRAC(8), .N_OSC(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [7:0] seed;
    logic [9:0] r;
    logic [7:0] exp_x;
  } vec_t;

  vec_t vecs[6];
  int   n_chk = 0;
  int   n_pass = 0;
  int   exp_slot = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] model(input logic [7:0] x, input logic [9:0] r);
    logic [7:0] nx;
    int p1, p2, res;
    nx  = ~x;
    p1  = (int'(x) * int'(nx)) >> 8;
    p2  = int'(r) * p1;
    res = (p2 >= 65536) ? 255 : ((p2 >> 8) & 255);
    if (res == 0) res = 1;
    return 8'(res);
  endfunction

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.x_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic finish_iter(input string name, input logic [7:0] exp_x);
    int n;
    wait_valid(n);
    chk({name, " latency"}, n, 16);
    chk({name, " x_out"}, bus.x_out, exp_x);
    chk({name, " slot"}, bus.slot, exp_slot);
    exp_slot = (exp_slot + 1) % 4;
    tick();
    chk({name, " single pulse"}, bus.x_valid, 0);
    chk({name, " idle busy"}, bus.busy, 0);
  endtask

  task automatic accept_run(input string name, input logic [9:0] r,
                            input logic [7:0] exp_x);
    bus.r_in  = r;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.r_in  = 10'h2A5;
    chk({name, " busy"}, bus.busy, 1);
    finish_iter(name, exp_x);
  endtask

  initial begin
    int seen;
    logic [7:0] xm;
    logic [9:0] fr_r;

    vecs[0] = '{8'h80, 10'h3FF, 8'hFB};
    vecs[1] = '{8'h01, 10'h100, 8'h01};
    vecs[2] = '{8'h40, 10'h200, 8'h5E};
    vecs[3] = '{8'hFF, 10'h3FF, 8'h01};
    vecs[4] = '{8'hC0, 10'h380, 8'hA4};
    vecs[5] = '{8'h00, 10'h3FF, 8'h01};

    reset         = 1'b1;
    bus.enable    = 1'b1;
    bus.start     = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed_x    = '0;
    bus.r_in      = '0;
    repeat (2) tick();
    reset = 1'b0;
    chk("reset x_out", bus.x_out, 8'h10);
    chk("reset slot", bus.slot, 0);
    chk("reset x_valid", bus.x_valid, 0);
    chk("reset busy", bus.busy, 0);

    accept_run("basic", 10'h110, 8'h0E);

    for (int i = 0; i < 6; i++) begin
      bus.seed_load = 1'b1;
      bus.seed_x    = vecs[i].seed;
      tick();
      bus.seed_load = 1'b0;
      chk($sformatf("vec%0d seed", i), bus.x_out, vecs[i].seed);
      accept_run($sformatf("vec%0d", i), vecs[i].r, vecs[i].exp_x);
    end

    bus.seed_load = 1'b1;
    bus.seed_x    = 8'h40;
    bus.start     = 1'b1;
    bus.r_in      = 10'h200;
    tick();
    chk("seed+start x_out", bus.x_out, 8'h40);
    chk("seed+start busy", bus.busy, 0);
    bus.seed_load = 1'b0;
    tick();
    bus.start = 1'b0;
    chk("seed then accept busy", bus.busy, 1);
    finish_iter("seed then accept", 8'h5E);

    bus.enable = 1'b0;
    bus.start  = 1'b1;
    repeat (3) tick();
    chk("enable low busy", bus.busy, 0);
    chk("enable low x_out", bus.x_out, 8'h5E);
    bus.start  = 1'b0;
    bus.enable = 1'b1;

    bus.r_in  = 10'h100;
    bus.start = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.enable = 1'b0;
    chk("enable drop busy", bus.busy, 1);
    finish_iter("enable drop", 8'h3B);
    bus.enable = 1'b1;

    bus.r_in  = 10'h110;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (8) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid reset busy", bus.busy, 0);
    chk("mid reset x_valid", bus.x_valid, 0);
    chk("mid reset x_out", bus.x_out, 8'h10);
    chk("mid reset slot", bus.slot, 0);
    exp_slot = 0;
    seen = 0;
    repeat (25) begin
      tick();
      if (bus.x_valid) seen++;
    end
    chk("mid reset no pulse", seen, 0);

    bus.seed_load = 1'b1;
    bus.seed_x    = 8'h80;
    tick();
    bus.seed_load = 1'b0;
    xm   = 8'h80;
    fr_r = 10'h3A0;
    bus.start = 1'b1;
    for (int c = 0; c < 90; c++) begin
      bus.r_in = (c % 18 == 0) ? fr_r : 10'($urandom);
      tick();
      if ((c + 1) % 18 == 17) begin
        xm = model(xm, fr_r);
        chk($sformatf("freerun c%0d valid", c + 1), bus.x_valid, 1);
        chk($sformatf("freerun c%0d x_out", c + 1), bus.x_out, xm);
        chk($sformatf("freerun c%0d slot", c + 1), bus.slot, exp_slot);
        exp_slot = (exp_slot + 1) % 4;
      end else begin
        chk($sformatf("freerun c%0d quiet", c + 1), bus.x_valid, 0);
      end
    end
    bus.start = 1'b0;
    tick();
    chk("freerun stop busy", bus.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
